handshake_elastic_fifo: RTL and testbench
=========================================

Name: handshake_elastic_fifo

Overview:
- Elastic FIFO buffer with valid/ready handshakes on both sides.
- Placed directly downstream of handshake constant/source stages to decouple their token production from consumer backpressure.
- Breaks the ready combinational path: ins_ready depends only on internal state.
- Stores up to NUM_SLOTS data tokens in order.

Parameters:
- DATA_WIDTH, 32, width of the data token.
- NUM_SLOTS, 4, FIFO depth. Must be >= 1; need not be a power of two.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- ins  input  DATA_WIDTH  upstream data.
- ins_valid  input  1  upstream token valid.
- ins_ready  output  1  FIFO accepts a token this cycle.
- outs  output  DATA_WIDTH  head-of-FIFO data.
- outs_valid  output  1  head token valid.
- outs_ready  input  1  downstream accepts the head token.

Behaviour:
- State:
  - storage array mem[NUM_SLOTS].
  - rd_ptr and wr_ptr, each clog2(NUM_SLOTS) bits, minimum 1 bit.
  - count, clog2(NUM_SLOTS+1) bits.
- Reset (async, rst=1):
  - rd_ptr=0, wr_ptr=0, count=0, all mem entries=0.
  - Outputs while in and directly after reset: outs_valid=0, ins_ready=1, outs=0.
- Combinational outputs:
  - full = (count==NUM_SLOTS); empty = (count==0).
  - ins_ready = !full.
  - outs_valid = !empty.
  - outs = mem[rd_ptr].
- Transfers per cycle:
  - push = ins_valid && ins_ready.
  - pop = outs_valid && outs_ready.
- On a push: mem[wr_ptr] <= ins; wr_ptr advances.
- On a pop: rd_ptr advances.
- Pointer wrap: NUM_SLOTS-1 -> 0 (explicit compare, not a power-of-two mask).
- Count update: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: a token accepted in cycle N appears on outs with outs_valid=1 in cycle N+1 at the earliest.
- Full: ins_ready=0 even if a pop happens in the same cycle (no same-cycle slot reuse). The slot frees in the next cycle.
- Empty: outs_valid=0 and outs holds stale mem contents. Downstream must ignore outs while outs_valid=0.
- Simultaneous push and pop with count in 1..NUM_SLOTS-1: both pointers advance and count is unchanged.
- Valid stability: once outs_valid=1 it stays high, and outs stays stable, until the pop. There is no retraction.
- Reset mid-operation: all buffered tokens are discarded immediately (asynchronously). No partial state survives.
- NUM_SLOTS=1: behaves as a one-slot opaque buffer with throughput 1/2.

Optional Feature:
- Macro: HANDSHAKE_FIFO_BYPASS_EN.
- Defined:
  - When empty and ins_valid=1: outs=ins and outs_valid=1 combinationally.
  - If outs_ready=1 in that cycle, the token passes through in 0 cycles and is not written, so count stays 0.
  - If outs_ready=0, the token is written normally.
  - Adds a combinational valid/data path; the ready path stays registered.
- Undefined: strict latency of 1 as described above, with no combinational path from ins to outs.

Decomposition:
- Shared package handshake_pkg holds:
  - clog2 helper function.
  - default DATA_WIDTH constant.
  - ptr/count width computation functions reused by other buffer blocks.
- One natural sub-module: handshake_fifo_ptr, a wrapping pointer counter parameterized by NUM_SLOTS with inc and rst inputs. Instantiate it twice, for rd_ptr and wr_ptr.
- Storage and count logic stay in the top module.

Test Plan:
- Reset check -> assert rst mid-stream with 3 tokens buffered -> same cycle outs_valid=0 and ins_ready=1; after release, the first new token 0x0A appears on outs one cycle after acceptance.
- Fill -> hold outs_ready=0 and drive ins=0x0A, 0x0B, 0x0C, 0x0D, 0x0E valid every cycle (NUM_SLOTS=4) -> first 4 accepted; ins_ready=0 from cycle 4 on; 0x0E held upstream.
- Drain order -> release outs_ready=1 after the fill -> outs sequence 0x0A, 0x0B, 0x0C, 0x0D on consecutive cycles, then outs_valid=0.
- Full plus pop -> FIFO full, outs_ready=1 and ins_valid=1 in the same cycle -> pop occurs, push refused; next cycle ins_ready=1 and 0x0E is accepted.
- Streaming -> continuous valid and ready with ins counting 0..99 -> throughput 1 token/cycle after the first, count constant at 1, outputs 0..99 in order across pointer wrap.
- NUM_SLOTS=3 wrap, plus bypass variant -> 10 tokens with random stalls give in-order output with no loss. With HANDSHAKE_FIFO_BYPASS_EN, an empty FIFO with ins=0x0A, ins_valid=1, outs_ready=1 gives outs=0x0A, outs_valid=1 in the same cycle, and count stays 0.

Source files
------------

// File: rtl/handshake_pkg.sv
// Shared helpers for handshake buffer blocks: ceil-log2 and pointer/count width rules.
package handshake_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

    // Pointers and counters never collapse to zero bits, even for a single slot.
    function automatic int ptr_width(input int num_slots);
        return (clog2(num_slots) < 1) ? 1 : clog2(num_slots);
    endfunction

    function automatic int count_width(input int num_slots);
        return (clog2(num_slots + 1) < 1) ? 1 : clog2(num_slots + 1);
    endfunction

endpackage

// File: rtl/handshake_fifo_ptr.sv
// Wrapping slot pointer: advances on inc and wraps NUM_SLOTS-1 -> 0 by explicit compare.
module handshake_fifo_ptr
    import handshake_pkg::*;
#(
    parameter int NUM_SLOTS = 4,
    localparam int PTR_W = ptr_width(NUM_SLOTS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [PTR_W-1:0] ptr
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(NUM_SLOTS - 1);

    logic [PTR_W-1:0] ptr_r;

    // Pointer register with wrap at the last slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_r <= {PTR_W{1'b0}};
        end else if (inc) begin
            if (ptr_r == LAST_PTR) begin
                ptr_r <= {PTR_W{1'b0}};
            end else begin
                ptr_r <= ptr_r + PTR_W'(1);
            end
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/handshake_elastic_fifo.sv
// Elastic valid/ready FIFO; ins_ready depends only on the occupancy register.
// Define HANDSHAKE_FIFO_BYPASS_EN for a zero-latency pass-through when empty.
module handshake_elastic_fifo
    import handshake_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int NUM_SLOTS  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] ins,
    input  logic                  ins_valid,
    output logic                  ins_ready,
    output logic [DATA_WIDTH-1:0] outs,
    output logic                  outs_valid,
    input  logic                  outs_ready
);

    localparam int PTR_W = ptr_width(NUM_SLOTS);
    localparam int CNT_W = count_width(NUM_SLOTS);

    logic [DATA_WIDTH-1:0] mem_r [NUM_SLOTS];
    logic [CNT_W-1:0]      count_r;
    logic [PTR_W-1:0]      rd_ptr_s;
    logic [PTR_W-1:0]      wr_ptr_s;
    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;

    assign full_s  = (count_r == CNT_W'(NUM_SLOTS));
    assign empty_s = (count_r == {CNT_W{1'b0}});

    // Handshake outputs and transfer qualifiers; ready never looks at outs_ready.
    always_comb begin
        ins_ready  = !full_s;
        outs       = mem_r[rd_ptr_s];
        outs_valid = !empty_s;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        if (empty_s) begin
            outs       = ins;
            outs_valid = ins_valid;
        end else begin
            outs       = mem_r[rd_ptr_s];
            outs_valid = 1'b1;
        end
        // A token consumed straight through is never written to storage.
        push_s = ins_valid && ins_ready && !(empty_s && outs_ready);
        pop_s  = !empty_s && outs_ready;
`else
        push_s = ins_valid && ins_ready;
        pop_s  = outs_valid && outs_ready;
`endif
    end

    handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .inc (pop_s),
        .ptr (rd_ptr_s)
    );

    handshake_fifo_ptr #(.NUM_SLOTS(NUM_SLOTS)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .inc (push_s),
        .ptr (wr_ptr_s)
    );

    // Token storage, cleared on reset so outs reads zero afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (push_s) begin
            mem_r[wr_ptr_s] <= ins;
        end
    end

    // Occupancy counter; simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: tb/tb_handshake_elastic_fifo.sv
// Directed bench: 4-slot FIFO (reset, fill, full+pop, drain, streaming) and 3-slot wrap with stalls.
module tb_handshake_elastic_fifo;

    logic        clk;
    logic        rst;
    logic [31:0] a_ins;
    logic        a_ins_valid;
    logic        a_ins_ready;
    logic [31:0] a_outs;
    logic        a_outs_valid;
    logic        a_outs_ready;

    logic [7:0]  b_ins;
    logic        b_ins_valid;
    logic        b_ins_ready;
    logic [7:0]  b_outs;
    logic        b_outs_valid;
    logic        b_outs_ready;

    int errors;
    int checks;

    handshake_elastic_fifo #(.DATA_WIDTH(32), .NUM_SLOTS(4)) dut_a (
        .clk        (clk),
        .rst        (rst),
        .ins        (a_ins),
        .ins_valid  (a_ins_valid),
        .ins_ready  (a_ins_ready),
        .outs       (a_outs),
        .outs_valid (a_outs_valid),
        .outs_ready (a_outs_ready)
    );

    handshake_elastic_fifo #(.DATA_WIDTH(8), .NUM_SLOTS(3)) dut_b (
        .clk        (clk),
        .rst        (rst),
        .ins        (b_ins),
        .ins_valid  (b_ins_valid),
        .ins_ready  (b_ins_ready),
        .outs       (b_outs),
        .outs_valid (b_outs_valid),
        .outs_ready (b_outs_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] in_pat;
        logic [15:0] out_pat;
        logic [7:0]  exp_q [$];
        logic [7:0]  exp_tok;
        int          cnt_m;
        int          sent;
        int          recv;
        int          cyc;
        logic        push_m;
        logic        pop_m;

        errors       = 0;
        checks       = 0;
        rst          = 1'b1;
        a_ins        = 32'h0;
        a_ins_valid  = 1'b0;
        a_outs_ready = 1'b0;
        b_ins        = 8'h0;
        b_ins_valid  = 1'b0;
        b_outs_ready = 1'b0;

        // Reset state
        tick();
        check_eq("rst_outs_valid", {31'b0, a_outs_valid}, 32'd0);
        check_eq("rst_ins_ready", {31'b0, a_ins_ready}, 32'd1);
        check_eq("rst_outs", a_outs, 32'h0);
        rst = 1'b0;
        tick();

        // Fill with outs_ready low: four accepted, 0x0E held upstream
        for (int k = 0; k < 5; k++) begin
            a_ins       = 32'h0A + 32'(k);
            a_ins_valid = 1'b1;
            #1;
            check_eq($sformatf("fill_ready_%0d", k), {31'b0, a_ins_ready}, (k < 4) ? 32'd1 : 32'd0);
            if (k == 0) begin
`ifdef HANDSHAKE_FIFO_BYPASS_EN
                check_eq("fill_first_valid", {31'b0, a_outs_valid}, 32'd1);
`else
                check_eq("fill_first_valid", {31'b0, a_outs_valid}, 32'd0);
`endif
            end
            if (k == 1) begin
                check_eq("fill_latency_valid", {31'b0, a_outs_valid}, 32'd1);
                check_eq("fill_latency_data", a_outs, 32'h0A);
            end
            tick();
        end

        // Full plus pop: pop happens, push refused this cycle
        a_ins        = 32'h0E;
        a_ins_valid  = 1'b1;
        a_outs_ready = 1'b1;
        #1;
        check_eq("fullpop_ready", {31'b0, a_ins_ready}, 32'd0);
        check_eq("fullpop_head", a_outs, 32'h0A);
        tick();
        check_eq("fullpop_next_ready", {31'b0, a_ins_ready}, 32'd1);
        check_eq("fullpop_next_head", a_outs, 32'h0B);
        tick();
        a_ins_valid = 1'b0;

        // Drain remaining tokens in order on consecutive cycles
        for (int k = 0; k < 3; k++) begin
            #1;
            check_eq($sformatf("drain_valid_%0d", k), {31'b0, a_outs_valid}, 32'd1);
            check_eq($sformatf("drain_data_%0d", k), a_outs, 32'h0C + 32'(k));
            tick();
        end
        check_eq("drain_empty", {31'b0, a_outs_valid}, 32'd0);

        // Reset mid-stream with three tokens buffered
        a_outs_ready = 1'b0;
        a_ins_valid  = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            a_ins = 32'(k);
            tick();
        end
        a_ins_valid = 1'b0;
        check_eq("pre_rst_valid", {31'b0, a_outs_valid}, 32'd1);
        check_eq("pre_rst_head", a_outs, 32'h1);
        rst = 1'b1;
        #1;
        check_eq("midrst_outs_valid", {31'b0, a_outs_valid}, 32'd0);
        check_eq("midrst_ins_ready", {31'b0, a_ins_ready}, 32'd1);
        check_eq("midrst_outs", a_outs, 32'h0);
        tick();
        rst = 1'b0;
        tick();
        a_ins       = 32'h0A;
        a_ins_valid = 1'b1;
        tick();
        a_ins_valid = 1'b0;
        #1;
        check_eq("postrst_valid", {31'b0, a_outs_valid}, 32'd1);
        check_eq("postrst_data", a_outs, 32'h0A);
        a_outs_ready = 1'b1;
        tick();
        check_eq("postrst_empty", {31'b0, a_outs_valid}, 32'd0);

        // Streaming 0..99 with both sides always active
        a_ins_valid  = 1'b1;
        a_outs_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            a_ins = 32'(i);
            #1;
            check_eq($sformatf("stream_ready_%0d", i), {31'b0, a_ins_ready}, 32'd1);
`ifndef HANDSHAKE_FIFO_BYPASS_EN
            if (i > 0) begin
                check_eq($sformatf("stream_valid_%0d", i), {31'b0, a_outs_valid}, 32'd1);
                check_eq($sformatf("stream_data_%0d", i), a_outs, 32'(i - 1));
            end
`else
            check_eq($sformatf("stream_data_%0d", i), a_outs, 32'(i));
`endif
            tick();
        end
        a_ins_valid = 1'b0;
        #1;
`ifndef HANDSHAKE_FIFO_BYPASS_EN
        check_eq("stream_last", a_outs, 32'd99);
        tick();
`endif
        check_eq("stream_empty", {31'b0, a_outs_valid}, 32'd0);

        // Empty FIFO with token offered and consumer ready
        a_ins        = 32'h0A;
        a_ins_valid  = 1'b1;
        a_outs_ready = 1'b1;
        #1;
`ifdef HANDSHAKE_FIFO_BYPASS_EN
        check_eq("bypass_valid", {31'b0, a_outs_valid}, 32'd1);
        check_eq("bypass_data", a_outs, 32'h0A);
        tick();
        a_ins_valid = 1'b0;
        #1;
        check_eq("bypass_not_stored", {31'b0, a_outs_valid}, 32'd0);
`else
        check_eq("nobypass_valid", {31'b0, a_outs_valid}, 32'd0);
        tick();
        a_ins_valid = 1'b0;
        #1;
        check_eq("nobypass_next_valid", {31'b0, a_outs_valid}, 32'd1);
        check_eq("nobypass_next_data", a_outs, 32'h0A);
        tick();
        check_eq("nobypass_drained", {31'b0, a_outs_valid}, 32'd0);
`endif
        a_outs_ready = 1'b0;

        // Three-slot FIFO: 10 tokens with fixed stall patterns against an occupancy model
        in_pat  = 16'b1011_0111_1101_1110;
        out_pat = 16'b0110_1011_0011_1101;
        cnt_m   = 0;
        sent    = 0;
        recv    = 0;
        cyc     = 0;
        while (recv < 10 && cyc < 200) begin
            b_ins        = 8'h10 + 8'(sent);
            b_ins_valid  = in_pat[cyc % 16] && (sent < 10);
            b_outs_ready = out_pat[cyc % 16];
            #1;
            check_eq($sformatf("w3_ready_c%0d", cyc), {31'b0, b_ins_ready}, (cnt_m < 3) ? 32'd1 : 32'd0);
`ifdef HANDSHAKE_FIFO_BYPASS_EN
            check_eq($sformatf("w3_valid_c%0d", cyc), {31'b0, b_outs_valid},
                     ((cnt_m > 0) || b_ins_valid) ? 32'd1 : 32'd0);
            push_m = b_ins_valid && (cnt_m < 3) && !((cnt_m == 0) && b_outs_ready);
            pop_m  = ((cnt_m > 0) || b_ins_valid) && b_outs_ready;
`else
            check_eq($sformatf("w3_valid_c%0d", cyc), {31'b0, b_outs_valid}, (cnt_m > 0) ? 32'd1 : 32'd0);
            push_m = b_ins_valid && (cnt_m < 3);
            pop_m  = (cnt_m > 0) && b_outs_ready;
`endif
            if (pop_m) begin
                if (cnt_m > 0) begin
                    exp_tok = exp_q.pop_front();
                end else begin
                    exp_tok = b_ins;
                end
                check_eq($sformatf("w3_data_%0d", recv), {24'b0, b_outs}, {24'b0, exp_tok});
                recv = recv + 1;
            end
            if (push_m) begin
                exp_q.push_back(b_ins);
            end
            if (b_ins_valid && (cnt_m < 3)) begin
                sent = sent + 1;
            end
            cnt_m = cnt_m + (push_m ? 1 : 0) - ((pop_m && cnt_m > 0) ? 1 : 0);
            tick();
            cyc = cyc + 1;
        end
        b_ins_valid  = 1'b0;
        b_outs_ready = 1'b0;
        check_eq("w3_all_received", 32'(recv), 32'd10);
        #1;
        check_eq("w3_empty_after", {31'b0, b_outs_valid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
